mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Shares the single main-memory bus port between the instruction cache (load-only) and the data cache (load/store).
- Picks one requester per cycle and forwards its command to memory. Routes the memory's accept response back to the winner only.
- Records which requester owns each outstanding 4-bit memory tag, so returning data/tag reaches the correct cache.
- Dcache has priority. A starvation counter guarantees icache forward progress.

Parameters:
- MAX_WAIT, 4, consecutive cycles icache may lose arbitration to dcache before icache is forced to win.
- NUM_TAGS, 16, size of owner table, indexed by memory tag; tag 0 means "none" and is never allocated.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- icache_command  in  2  BUS_NONE/BUS_LOAD from icache
- icache_addr  in  64  icache request address
- dcache_command  in  2  BUS_NONE/BUS_LOAD/BUS_STORE from dcache
- dcache_addr  in  64  dcache request address
- dcache_data  in  64  dcache store data
- mem2proc_response  in  4  memory accept tag; 0 = rejected
- mem2proc_data  in  64  memory return data
- mem2proc_tag  in  4  tag of returning data; 0 = none
- proc2mem_command  out  2  winning command
- proc2mem_addr  out  64  winning address
- proc2mem_data  out  64  winning store data (0 for loads or idle)
- icache_response  out  4  mem2proc_response if icache won, else 0
- dcache_response  out  4  mem2proc_response if dcache won, else 0
- icache_tag  out  4  returning tag if owned by icache, else 0
- dcache_tag  out  4  returning tag if owned by dcache, else 0
- icache_data / dcache_data_out  out  64 each  mem2proc_data; valid only when the matching tag output is nonzero
- grant_dcache  out  1  1 = dcache owns bus this cycle
- tag_error  out  1  sticky; set on return of an unowned tag, or on allocation of an already-valid tag

Behaviour:
- Arbitration (combinational, same cycle):
  - force_i = (starve_cnt == MAX_WAIT).
  - If force_i and icache_command != BUS_NONE, icache wins.
  - Else if dcache_command != BUS_NONE, dcache wins.
  - Else if icache_command != BUS_NONE, icache wins.
  - Else idle: proc2mem_command = BUS_NONE, addr = 0, data = 0, grant_dcache = 0.
- Response routing is combinational; the loser always sees response 0 and must re-present its request.
- starve_cnt: 0..MAX_WAIT, saturating.
  - Increments when icache requests and dcache wins.
  - Clears when icache wins and mem2proc_response != 0, or when icache_command == BUS_NONE.
  - Holds when icache wins but memory rejects (response 0); it stays at MAX_WAIT so the retry keeps priority.
- Owner table: NUM_TAGS entries of {valid, owner}, where owner 0 = icache and 1 = dcache.
  - Allocation at posedge when the winning command is BUS_LOAD and mem2proc_response != 0.
  - Sets entry[response] = {1, winner}.
  - Accepted stores allocate nothing.
- Return path (combinational lookup):
  - When mem2proc_tag != 0 and entry[tag].valid, drive the owner's tag output = mem2proc_tag; the other side gets 0.
  - Entry clears at posedge.
  - If the entry is invalid, both tag outputs are 0 and tag_error sets.
- Simultaneous events:
  - Return and allocation of the same tag in one cycle: the clear applies first, then the allocation; the entry ends valid with the new owner, and no tag_error.
  - Allocation onto a valid entry with no same-cycle return: overwrite and set tag_error.
- Latency: 0 cycles for the grant, response and return routing; table and counter update at the next posedge.
- Reset (asynchronous, reset == 0): table all invalid, starve_cnt = 0, tag_error = 0. All combinational outputs follow idle inputs. Tags outstanding at reset are forgotten; their later returns set tag_error.
- Response routing and data pass-through are combinational; the table and counter are the only state.

Optional Feature:
- ARB_PERF_CNT_EN: when defined, adds three 32-bit outputs, each saturating and cleared on reset:
  - perf_icache_grants: accepted icache loads.
  - perf_dcache_grants: accepted dcache loads and stores.
  - perf_icache_stall: cycles icache requested but lost to dcache.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Icache LOAD 0x100 only, response 3:
  - Same cycle: proc2mem_addr=0x100, icache_response=3, dcache_response=0.
  - Later mem2proc_tag=3: icache_tag=3, dcache_tag=0.
- Both request every cycle, memory always accepts, MAX_WAIT=4:
  - Dcache wins cycles 0-3, icache wins cycle 4, dcache wins cycle 5.
  - starve_cnt sequence 1,2,3,4,0,1.
- Dcache STORE 0x200, data 0xDEAD, response 5:
  - proc2mem_data=0xDEAD, dcache_response=5; no table entry.
  - Later mem2proc_tag=5 gives both tags 0 and tag_error=1.
- Icache load tagged 7 returns in the same cycle a dcache load is accepted with response 7:
  - icache_tag=7; entry 7 becomes owner dcache; tag_error stays 0.
- Icache wins at starve_cnt=4 but response=0 for 2 cycles:
  - Icache keeps winning and starve_cnt holds 4.
  - On response=2, starve_cnt clears to 0.
- Assert reset low mid-stream with 3 outstanding tags:
  - Table clears immediately.
  - After release, return of one of those tags gives both tag outputs 0 and tag_error=1.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single memory bus port between icache (loads) and dcache (loads/stores)
// and tracks which cache owns each outstanding tag. Optional perf counters: ARB_PERF_CNT_EN.
module mem_bus_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int NUM_TAGS = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  icache_command,
  input  logic [63:0] icache_addr,
  input  logic [1:0]  dcache_command,
  input  logic [63:0] dcache_addr,
  input  logic [63:0] dcache_data,
  input  logic [3:0]  mem2proc_response,
  input  logic [63:0] mem2proc_data,
  input  logic [3:0]  mem2proc_tag,
  output logic [1:0]  proc2mem_command,
  output logic [63:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  output logic [3:0]  icache_response,
  output logic [3:0]  dcache_response,
  output logic [3:0]  icache_tag,
  output logic [3:0]  dcache_tag,
  output logic [63:0] icache_data,
  output logic [63:0] dcache_data_out,
  output logic        grant_dcache,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0] perf_icache_grants,
  output logic [31:0] perf_dcache_grants,
  output logic [31:0] perf_icache_stall,
`endif
  output logic        tag_error
);

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;
  localparam int         CW        = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {WIN_NONE, WIN_ICACHE, WIN_DCACHE} winner_e;

  winner_e             winner;
  logic [CW-1:0]       starve_cnt;
  logic [NUM_TAGS-1:0] tag_valid;
  logic [NUM_TAGS-1:0] tag_owner;   // 0 = icache, 1 = dcache
  logic                force_i;
  logic                icache_req;
  logic                alloc;
  logic                ret_hit;
  logic                ret_miss;
  logic                alloc_clash;

  assign icache_req = (icache_command != BUS_NONE);
  assign force_i    = (starve_cnt == CW'(MAX_WAIT));

  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    winner           = WIN_NONE;
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (force_i && icache_req)            winner = WIN_ICACHE;
    else if (dcache_command != BUS_NONE)  winner = WIN_DCACHE;
    else if (icache_req)                  winner = WIN_ICACHE;
    if (winner == WIN_ICACHE) begin
      proc2mem_command = icache_command;
      proc2mem_addr    = icache_addr;
    end else if (winner == WIN_DCACHE) begin
      proc2mem_command = dcache_command;
      proc2mem_addr    = dcache_addr;
      proc2mem_data    = (dcache_command == BUS_STORE) ? dcache_data : '0;
    end
  end

  assign grant_dcache    = (winner == WIN_DCACHE);
  assign icache_response = (winner == WIN_ICACHE) ? mem2proc_response : '0;
  assign dcache_response = (winner == WIN_DCACHE) ? mem2proc_response : '0;

  assign ret_hit     = (mem2proc_tag != '0) && tag_valid[mem2proc_tag];
  assign ret_miss    = (mem2proc_tag != '0) && !tag_valid[mem2proc_tag];
  assign icache_tag  = (ret_hit && !tag_owner[mem2proc_tag]) ? mem2proc_tag : '0;
  assign dcache_tag  = (ret_hit &&  tag_owner[mem2proc_tag]) ? mem2proc_tag : '0;
  assign icache_data     = mem2proc_data;
  assign dcache_data_out = mem2proc_data;

  assign alloc       = (proc2mem_command == BUS_LOAD) && (mem2proc_response != '0);
  // Reallocating a tag that is returning this very cycle is legal reuse, not a clash.
  assign alloc_clash = alloc && tag_valid[mem2proc_response] && (mem2proc_tag != mem2proc_response);

  // NOTE: the owner table is only 16x2 flops, so it is reset outright; outstanding tags are forgotten.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag_valid <= '0;
      tag_owner <= '0;
      tag_error <= 1'b0;
    end else begin
      // NOTE: non-blocking order matters here: the later allocation write overrides the same-tag clear.
      if (mem2proc_tag != '0) tag_valid[mem2proc_tag] <= 1'b0;
      if (alloc) begin
        tag_valid[mem2proc_response] <= 1'b1;
        tag_owner[mem2proc_response] <= grant_dcache;
      end
      if (ret_miss || alloc_clash) tag_error <= 1'b1;
    end
  end

  // Rejected forced retries hold the count at MAX_WAIT so icache keeps priority.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!icache_req) begin
      starve_cnt <= '0;
    end else if (winner == WIN_DCACHE) begin
      if (!force_i) starve_cnt <= starve_cnt + CW'(1);
    end else if (winner == WIN_ICACHE && mem2proc_response != '0) begin
      starve_cnt <= '0;
    end
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_icache_grants <= '0;
      perf_dcache_grants <= '0;
      perf_icache_stall  <= '0;
    end else begin
      if (winner == WIN_ICACHE && icache_command == BUS_LOAD && mem2proc_response != '0 &&
          perf_icache_grants != '1)
        perf_icache_grants <= perf_icache_grants + 32'd1;
      if (winner == WIN_DCACHE && mem2proc_response != '0 && perf_dcache_grants != '1)
        perf_dcache_grants <= perf_dcache_grants + 32'd1;
      if (icache_req && winner == WIN_DCACHE && perf_icache_stall != '1)
        perf_icache_stall <= perf_icache_stall + 32'd1;
    end
  end
`endif

endmodule
